// File: rtl/mnist_frame_streamer.sv
// Frame buffer that loads one 28x28 grey-scale image from a host port and replays it as a de/pixel stream.
// Optional build macro MNIST_STREAM_INVERT_EN inverts pixel polarity on the output register.
module mnist_frame_streamer #(
    parameter int GRAY_WIDTH = 8,
    parameter int PIXEL_NUM  = 784,
    parameter int ROW_LEN    = 28,
    parameter int ADDR_WIDTH = 10,
    parameter int LINE_GAP   = 0
) (
    input  logic                  pclk,
    input  logic                  rst,
    input  logic                  wr_valid,
    output logic                  wr_ready,
    input  logic [GRAY_WIDTH-1:0] wr_pixel,
    input  logic                  clear,
    input  logic                  start,
    output logic                  loaded,
    output logic                  busy,
    output logic                  de,
    output logic [GRAY_WIDTH-1:0] pixel_out,
    output logic                  frame_done
);

    localparam logic [1:0] ST_LOAD   = 2'd0;
    localparam logic [1:0] ST_READY  = 2'd1;
    localparam logic [1:0] ST_STREAM = 2'd2;
    localparam logic [1:0] ST_GAP    = 2'd3;

    localparam int COL_W = (ROW_LEN > 1) ? $clog2(ROW_LEN) : 1;
    localparam int GAP_W = (LINE_GAP > 1) ? $clog2(LINE_GAP) : 1;

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(PIXEL_NUM - 1);
    localparam logic [COL_W-1:0]      LAST_COL  = COL_W'(ROW_LEN - 1);
    localparam logic [GAP_W-1:0]      GAP_LAST  = GAP_W'((LINE_GAP > 0) ? LINE_GAP - 1 : 0);
    localparam logic                  GAP_EN    = (LINE_GAP > 0);

    function automatic logic [GRAY_WIDTH-1:0] shape_pixel(input logic [GRAY_WIDTH-1:0] p);
`ifdef MNIST_STREAM_INVERT_EN
        return ~p;
`else
        return p;
`endif
    endfunction

    logic [GRAY_WIDTH-1:0] mem [PIXEL_NUM];

    logic [1:0]            state;
    logic [1:0]            state_nx;
    logic [ADDR_WIDTH-1:0] wr_cnt;
    logic [ADDR_WIDTH-1:0] rd_cnt;
    logic [COL_W-1:0]      col_cnt;
    logic [GAP_W-1:0]      gap_cnt;

    logic                  wr_en;
    logic                  rd_en;
    logic                  start_ok;
    logic                  row_end;
    logic                  frame_end;

    logic [GRAY_WIDTH-1:0] pix_p0;
    logic                  vld_p0;
    logic                  last_p0;
    logic                  vld_p1;
    logic                  last_p1;

    // wr_ready is only ever high while in LOAD, so it also qualifies the write state.
    assign wr_en     = wr_valid & wr_ready & ~clear;
    assign rd_en     = (state == ST_STREAM);
    assign row_end   = (col_cnt == LAST_COL);
    assign frame_end = (rd_cnt == LAST_ADDR);
    // A new replay may begin no earlier than the frame_done cycle of the previous one.
    assign start_ok  = start & ~clear & (state == ST_READY) & (~busy | frame_done);
    assign de        = vld_p1;

    always_comb begin
        state_nx = state;
        unique case (state)
            ST_LOAD:   if (wr_en && (wr_cnt == LAST_ADDR)) state_nx = ST_READY;
            ST_READY:  if (start_ok) state_nx = ST_STREAM;
            ST_STREAM: begin
                if (frame_end)             state_nx = ST_READY;
                else if (row_end && GAP_EN) state_nx = ST_GAP;
            end
            ST_GAP:    if (gap_cnt == GAP_LAST) state_nx = ST_STREAM;
            default:   state_nx = ST_LOAD;
        endcase
        if (clear) state_nx = ST_LOAD;
    end

    always_ff @(posedge pclk or negedge rst) begin
        if (!rst) begin
            state      <= ST_LOAD;
            wr_ready   <= 1'b0;
            wr_cnt     <= '0;
            loaded     <= 1'b0;
            rd_cnt     <= '0;
            col_cnt    <= '0;
            gap_cnt    <= '0;
            busy       <= 1'b0;
            vld_p0     <= 1'b0;
            last_p0    <= 1'b0;
            vld_p1     <= 1'b0;
            last_p1    <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            state    <= state_nx;
            wr_ready <= (state_nx == ST_LOAD);

            if (clear) begin
                wr_cnt <= '0;
                loaded <= 1'b0;
            end else if (wr_en) begin
                if (wr_cnt == LAST_ADDR) loaded <= 1'b1;
                else                     wr_cnt <= wr_cnt + 1'b1;
            end

            if (start_ok) begin
                rd_cnt  <= '0;
                col_cnt <= '0;
            end else if (rd_en && !frame_end) begin
                rd_cnt  <= rd_cnt + 1'b1;
                col_cnt <= row_end ? '0 : col_cnt + 1'b1;
            end

            gap_cnt <= (state == ST_GAP) ? gap_cnt + 1'b1 : '0;

            if (clear)           busy <= 1'b0;
            else if (start_ok)   busy <= 1'b1;
            else if (frame_done) busy <= 1'b0;

            // p0: read issued, RAM data returns
            vld_p0     <= rd_en & ~clear;
            last_p0    <= rd_en & frame_end & ~clear;
            // p1: registered stream output
            vld_p1     <= vld_p0 & ~clear;
            last_p1    <= last_p0 & ~clear;
            frame_done <= last_p1 & ~clear;
        end
    end

    always_ff @(posedge pclk) begin
        if (wr_en) mem[wr_cnt] <= wr_pixel;
        if (rd_en) pix_p0 <= mem[rd_cnt];
    end

    always_ff @(posedge pclk or negedge rst) begin
        if (!rst)        pixel_out <= '0;
        else if (vld_p0) pixel_out <= shape_pixel(pix_p0);
    end

endmodule

// File: tb/tb_mnist_frame_streamer.sv
// Scoreboard bench for mnist_frame_streamer: two instances (LINE_GAP 0 and 2) share one stimulus stream.
module tb_mnist_frame_streamer;

    localparam int GW   = 8;
    localparam int NPIX = 784;
    localparam int RL   = 28;
    localparam int AW   = 10;
    localparam int GAP0 = 0;
    localparam int GAP1 = 2;

    logic          pclk = 1'b0;
    logic          rst = 1'b1;
    logic          wr_valid = 1'b0;
    logic          clear = 1'b0;
    logic          start = 1'b0;
    logic [GW-1:0] wr_pixel = '0;

    logic          wr_ready0, loaded0, busy0, de0, fd0;
    logic [GW-1:0] pix0;
    logic          wr_ready1, loaded1, busy1, de1, fd1;
    logic [GW-1:0] pix1;

    mnist_frame_streamer #(.GRAY_WIDTH(GW), .PIXEL_NUM(NPIX), .ROW_LEN(RL),
                           .ADDR_WIDTH(AW), .LINE_GAP(GAP0)) u_dut (
        .pclk(pclk), .rst(rst), .wr_valid(wr_valid), .wr_ready(wr_ready0),
        .wr_pixel(wr_pixel), .clear(clear), .start(start), .loaded(loaded0),
        .busy(busy0), .de(de0), .pixel_out(pix0), .frame_done(fd0));

    mnist_frame_streamer #(.GRAY_WIDTH(GW), .PIXEL_NUM(NPIX), .ROW_LEN(RL),
                           .ADDR_WIDTH(AW), .LINE_GAP(GAP1)) u_gap (
        .pclk(pclk), .rst(rst), .wr_valid(wr_valid), .wr_ready(wr_ready1),
        .wr_pixel(wr_pixel), .clear(clear), .start(start), .loaded(loaded1),
        .busy(busy1), .de(de1), .pixel_out(pix1), .frame_done(fd1));

    always #5 pclk = ~pclk;

    int cyc = 0;
    always @(posedge pclk) cyc <= cyc + 1;

    typedef struct {
        int            c;
        logic [GW-1:0] p;
    } exp_t;

    exp_t pq0[$];
    exp_t pq1[$];
    int   fq0[$];
    int   fq1[$];
    int   n_chk = 0;
    int   n_pass = 0;
    logic [GW-1:0] frame [NPIX];

    task automatic chk(input string nm, input longint act, input longint req);
        n_chk++;
        if (act == req) n_pass++;
        else $display("FAIL %s: got %0d, required %0d (cycle %0d)", nm, act, req, cyc);
    endtask

    function automatic logic [GW-1:0] model_pix(input logic [GW-1:0] s);
`ifdef MNIST_STREAM_INVERT_EN
        return 8'hFF - s;
`else
        return s;
`endif
    endfunction

    // Expected stream for a start sampled at edge t: pixel k appears at t+2+k plus the row gaps before it.
    task automatic push_frame(input int t);
        exp_t e;
        for (int d = 0; d < 2; d++) begin
            int g;
            g = (d == 0) ? GAP0 : GAP1;
            for (int k = 0; k < NPIX; k++) begin
                e.c = t + 2 + k + (k / RL) * g;
                e.p = model_pix(frame[k]);
                if (d == 0) pq0.push_back(e);
                else        pq1.push_back(e);
            end
            if (d == 0) fq0.push_back(t + 2 + NPIX + (NPIX / RL - 1) * g);
            else        fq1.push_back(t + 2 + NPIX + (NPIX / RL - 1) * g);
        end
    endtask

    task automatic purge_after(input int m);
        while (pq0.size() > 0 && pq0[$].c > m) void'(pq0.pop_back());
        while (pq1.size() > 0 && pq1[$].c > m) void'(pq1.pop_back());
        while (fq0.size() > 0 && fq0[$] > m) void'(fq0.pop_back());
        while (fq1.size() > 0 && fq1[$] > m) void'(fq1.pop_back());
    endtask

    task automatic mon(input int d, input logic de_i, input logic [GW-1:0] pix_i,
                       input logic fd_i, input logic busy_i);
        exp_t e;
        int   n;
        int   fc;
        if (de_i) begin
            n = (d == 0) ? pq0.size() : pq1.size();
            if (n == 0) chk($sformatf("de_pending_u%0d", d), n, 1);
            else begin
                if (d == 0) e = pq0.pop_front();
                else        e = pq1.pop_front();
                chk($sformatf("pixel_u%0d", d), pix_i, e.p);
                chk($sformatf("de_cycle_u%0d", d), cyc, e.c);
            end
        end
        if (fd_i) begin
            n = (d == 0) ? fq0.size() : fq1.size();
            if (n == 0) chk($sformatf("frame_done_pending_u%0d", d), n, 1);
            else begin
                if (d == 0) fc = fq0.pop_front();
                else        fc = fq1.pop_front();
                chk($sformatf("frame_done_cycle_u%0d", d), cyc, fc);
                chk($sformatf("busy_at_done_u%0d", d), busy_i, 1);
            end
        end
    endtask

    always @(negedge pclk) begin
        mon(0, de0, pix0, fd0, busy0);
        mon(1, de1, pix1, fd1, busy1);
    end

    task automatic step();
        @(posedge pclk);
        #1;
    endtask

    task automatic load_frame();
        int k;
        int b;
        logic acc;
        k = 0;
        b = 0;
        while (k < NPIX && b < 5000) begin
            wr_valid = (($urandom % 4) != 0);
            wr_pixel = frame[k];
            acc = wr_valid & wr_ready0;
            step();
            if (acc) k++;
            b++;
        end
        wr_valid = 1'b0;
        chk("load_accepted", k, NPIX);
        chk("loaded_after_load", loaded0, 1);
    endtask

    task automatic drain();
        int b;
        b = 0;
        while ((pq0.size() + pq1.size() + fq0.size() + fq1.size()) > 0 && b < 3000) begin
            step();
            b++;
        end
        chk("drain_left", pq0.size() + pq1.size() + fq0.size() + fq1.size(), 0);
        step();
        step();
        chk("busy_idle_u0", busy0, 0);
        chk("busy_idle_u1", busy1, 0);
    endtask

    task automatic issue_start(output int t);
        start = 1'b1;
        t = cyc + 1;
        push_frame(t);
        step();
        start = 1'b0;
        chk("busy_after_start_u0", busy0, 1);
        chk("busy_after_start_u1", busy1, 1);
    endtask

    task automatic replay(input bit poke_start);
        int t;
        issue_start(t);
        if (poke_start) begin
            while (cyc < t + 50) step();
            start = 1'b1;
            step();
            start = 1'b0;
        end
        drain();
    endtask

    task automatic do_clear();
        clear = 1'b1;
        step();
        clear = 1'b0;
        chk("loaded_after_clear", loaded0, 0);
        chk("wr_ready_after_clear", wr_ready0, 1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        int m;
        #1 rst = 1'b0;
        #1;
        chk("rst_wr_ready", wr_ready0, 0);
        chk("rst_loaded", loaded0, 0);
        chk("rst_busy", busy0, 0);
        chk("rst_de", de0, 0);
        chk("rst_pixel_out", pix0, 0);
        chk("rst_frame_done", fd0, 0);
        repeat (3) step();
        chk("wr_ready_in_reset", wr_ready0, 0);
        rst = 1'b1;
        chk("wr_ready_at_release", wr_ready0, 0);
        step();
        chk("wr_ready_after_release", wr_ready0, 1);

        // Ramp frame, write back-pressure, replay with an ignored mid-stream start
        for (int k = 0; k < NPIX; k++) frame[k] = 8'(k);
        load_frame();
        wr_valid = 1'b1;
        repeat (10) begin
            wr_pixel = 8'($urandom);
            step();
            chk("bp_wr_ready", wr_ready0, 0);
            chk("bp_loaded", loaded0, 1);
        end
        wr_valid = 1'b0;
        replay(1'b1);
        replay(1'b0);

        // Random frame
        do_clear();
        for (int k = 0; k < NPIX; k++) frame[k] = 8'($urandom);
        load_frame();
        replay(1'b0);

        // Abort on the 100th de cycle
        issue_start(t);
        while (cyc < t + 101) step();
        m = cyc;
        clear = 1'b1;
        purge_after(m);
        step();
        clear = 1'b0;
        chk("abort_loaded", loaded0, 0);
        chk("abort_wr_ready", wr_ready0, 1);
        chk("abort_de_u0", de0, 0);
        chk("abort_de_u1", de1, 0);
        chk("abort_busy", busy0, 0);

        // A write coinciding with clear is dropped, then an all-0x55 frame
        wr_valid = 1'b1;
        wr_pixel = 8'hAA;
        clear = 1'b1;
        step();
        wr_valid = 1'b0;
        clear = 1'b0;
        for (int k = 0; k < NPIX; k++) frame[k] = 8'h55;
        load_frame();
        replay(1'b0);

        // clear wins over start
        clear = 1'b1;
        start = 1'b1;
        step();
        clear = 1'b0;
        start = 1'b0;
        chk("clear_start_loaded", loaded0, 0);
        chk("clear_start_busy", busy0, 0);
        repeat (10) step();
        chk("clear_start_idle", busy0, 0);

        // Constant 0x10 frame (polarity check)
        for (int k = 0; k < NPIX; k++) frame[k] = 8'h10;
        load_frame();
        replay(1'b0);

        // Asynchronous reset mid-stream
        issue_start(t);
        repeat (60) step();
        #2 rst = 1'b0;
        pq0.delete();
        pq1.delete();
        fq0.delete();
        fq1.delete();
        #1;
        chk("mid_rst_de_u0", de0, 0);
        chk("mid_rst_de_u1", de1, 0);
        chk("mid_rst_busy", busy0, 0);
        chk("mid_rst_pixel_out", pix0, 0);
        chk("mid_rst_frame_done", fd0, 0);
        chk("mid_rst_loaded", loaded0, 0);
        chk("mid_rst_wr_ready", wr_ready0, 0);
        step();
        rst = 1'b1;
        step();
        chk("post_rst_wr_ready", wr_ready0, 1);
        chk("post_rst_loaded", loaded0, 0);
        start = 1'b1;
        step();
        start = 1'b0;
        repeat (20) step();
        chk("unloaded_start_busy_u0", busy0, 0);
        chk("unloaded_start_busy_u1", busy1, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
